// File: rtl/ysyx_23060072_ex_stage_pkg.sv
// Shared encodings for the RV32E execute stage: ALU, branch, multiply and
// LSU access-size codes, plus the multiplier FSM states.
package ysyx_23060072_ex_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_e;

    // Branch codes follow the RISC-V funct3 field
    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd4,
        BR_BGE  = 3'd5,
        BR_BLTU = 3'd6,
        BR_BGEU = 3'd7
    } br_type_e;

    typedef enum logic [1:0] {
        MUL_MUL    = 2'd0,
        MUL_MULH   = 2'd1,
        MUL_MULHSU = 2'd2,
        MUL_MULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'd0,
        LSU_HALF = 2'd1,
        LSU_WORD = 2'd2
    } lsu_type_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    localparam logic [4:0] MUL_LAST_STEP = 5'd31;

endpackage

// File: rtl/ysyx_23060072_ex_stage_mul.sv
// Iterative shift-add multiplier (one partial product per cycle). Operands are
// converted to magnitudes at entry and the sign is reapplied to the 64-bit
// product, so one unsigned datapath serves MUL/MULH/MULHSU/MULHU.
// Only instantiated when YSYX_23060072_MUL_EN is defined.
module ysyx_23060072_mul
    import ysyx_23060072_ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        hold,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic [31:0] result
);

    mul_state_e  state, state_next;
    logic        start;
    logic [63:0] mcand, product, product_signed;
    logic [31:0] mplier;
    logic [4:0]  count;
    logic        negate;
    logic [1:0]  op_q;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    assign a_neg = (op != MUL_MULHU) & operand_a[31];
    assign b_neg = ((op == MUL_MUL) | (op == MUL_MULH)) & operand_b[31];
    assign a_mag = a_neg ? (~operand_a + 32'd1) : operand_a;
    assign b_mag = b_neg ? (~operand_b + 32'd1) : operand_b;

    // State register; synchronous reset drops any multiply in flight
    always_ff @(posedge clk) begin
        if (!rst_n) state <= MUL_IDLE;
        else        state <= state_next;
    end

    // Next state and stall request; entry raises busy in the same cycle
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        start      = 1'b0;
        case (state)
            MUL_IDLE: begin
                if (req && !hold) begin
                    start      = 1'b1;
                    busy       = 1'b1;
                    state_next = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                busy = 1'b1;
                if (count == MUL_LAST_STEP) state_next = MUL_DONE;
            end
            MUL_DONE: begin
                if (req && !hold) state_next = MUL_IDLE;
            end
            default: state_next = MUL_IDLE;
        endcase
    end

    // Operand capture at entry, then one shift-add step per busy cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand   <= 64'd0;
            mplier  <= 32'd0;
            product <= 64'd0;
            count   <= 5'd0;
            negate  <= 1'b0;
            op_q    <= 2'd0;
        end else if (start) begin
            mcand   <= {32'd0, a_mag};
            mplier  <= b_mag;
            product <= 64'd0;
            count   <= 5'd0;
            negate  <= a_neg ^ b_neg;
            op_q    <= op;
        end else if (state == MUL_BUSY) begin
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
        end
    end

    assign product_signed = negate ? (~product + 64'd1) : product;
    assign result = (op_q == MUL_MUL) ? product_signed[31:0] : product_signed[63:32];

endmodule

// File: rtl/ysyx_23060072_ex_stage.sv
// RV32E execute stage: ALU, branch/jump resolution and the EX/LSU pipeline
// register. Define YSYX_23060072_MUL_EN to add the iterative multiplier;
// without it M-extension ops retire as NOPs and ex_hold_flag_o stays 0.
module ysyx_23060072_ex_stage
    import ysyx_23060072_ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [3:0]  alu_op_i,
    input  logic        use_imm_i,
    input  logic        branch_i,
    input  logic        jal_i,
    input  logic        jalr_i,
    input  logic [2:0]  branch_type_i,
    input  logic        mul_flag_i,
    input  logic [1:0]  mul_op_i,
    input  logic        wb_flag_i,
    input  logic        store_flag_i,
    input  logic        load_flag_i,
    input  logic        LSU_signed_i,
    input  logic [1:0]  LSU_type_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic [31:0] operand_imm_i,
    input  logic [4:0]  wb_addr_i,
    input  logic        hold_i,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        ex_hold_flag_o,
    output logic        wb_flag_o,
    output logic        store_flag_o,
    output logic        load_flag_o,
    output logic        LSU_signed_o,
    output logic [1:0]  LSU_type_o,
    output logic [31:0] pc_o,
    output logic [31:0] wb_data_o,
    output logic [31:0] operand_a_o,
    output logic [31:0] operand_b_o,
    output logic [31:0] operand_imm_o,
    output logic [4:0]  wb_addr_o
);

    logic [31:0] alu_b, alu_result, link_addr, jalr_sum, wb_data_next;
    logic        branch_taken, accept, wb_flag_next;

`ifdef YSYX_23060072_MUL_EN
    logic [31:0] mul_result;

    ysyx_23060072_mul u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (valid_i & mul_flag_i),
        .hold      (hold_i),
        .op        (mul_op_i),
        .operand_a (operand_a_i),
        .operand_b (operand_b_i),
        .busy      (ex_hold_flag_o),
        .result    (mul_result)
    );

    assign wb_flag_next = wb_flag_i;
    assign wb_data_next = mul_flag_i ? mul_result :
                          (jal_i | jalr_i) ? link_addr : alu_result;
`else
    logic [1:0] unused_mul_op;

    assign unused_mul_op  = mul_op_i;
    assign ex_hold_flag_o = 1'b0;
    assign wb_flag_next   = wb_flag_i & ~mul_flag_i;
    assign wb_data_next   = (jal_i | jalr_i) ? link_addr : alu_result;
`endif

    assign alu_b     = use_imm_i ? operand_imm_i : operand_b_i;
    assign link_addr = pc_i + 32'd4;
    assign jalr_sum  = operand_a_i + operand_imm_i;
    assign accept    = valid_i & ~hold_i & ~ex_hold_flag_o;

    // ALU result selection
    always_comb begin
        alu_result = 32'd0;
        case (alu_op_i)
            ALU_ADD:   alu_result = operand_a_i + alu_b;
            ALU_SUB:   alu_result = operand_a_i - alu_b;
            ALU_SLL:   alu_result = operand_a_i << alu_b[4:0];
            ALU_SLT:   alu_result = {31'd0, $signed(operand_a_i) < $signed(alu_b)};
            ALU_SLTU:  alu_result = {31'd0, operand_a_i < alu_b};
            ALU_XOR:   alu_result = operand_a_i ^ alu_b;
            ALU_SRL:   alu_result = operand_a_i >> alu_b[4:0];
            ALU_SRA:   alu_result = $unsigned($signed(operand_a_i) >>> alu_b[4:0]);
            ALU_OR:    alu_result = operand_a_i | alu_b;
            ALU_AND:   alu_result = operand_a_i & alu_b;
            ALU_LUI:   alu_result = alu_b;
            ALU_AUIPC: alu_result = pc_i + alu_b;
            default:   alu_result = 32'd0;
        endcase
    end

    // Branch comparator always works on the register operands
    always_comb begin
        branch_taken = 1'b0;
        case (branch_type_i)
            BR_BEQ:  branch_taken = (operand_a_i == operand_b_i);
            BR_BNE:  branch_taken = (operand_a_i != operand_b_i);
            BR_BLT:  branch_taken = ($signed(operand_a_i) <  $signed(operand_b_i));
            BR_BGE:  branch_taken = ($signed(operand_a_i) >= $signed(operand_b_i));
            BR_BLTU: branch_taken = (operand_a_i <  operand_b_i);
            BR_BGEU: branch_taken = (operand_a_i >= operand_b_i);
            default: branch_taken = 1'b0;
        endcase
    end

    // Redirect is gated by accept so it fires once per instruction, never in reset
    assign jump_flag_o = rst_n & accept & (jal_i | jalr_i | (branch_i & branch_taken));
    assign jump_addr_o = jalr_i ? {jalr_sum[31:1], 1'b0} : (pc_i + operand_imm_i);

    // EX/LSU register: load on accept, freeze on hold, otherwise issue a bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_flag_o     <= 1'b0;
            store_flag_o  <= 1'b0;
            load_flag_o   <= 1'b0;
            LSU_signed_o  <= 1'b0;
            LSU_type_o    <= 2'd0;
            pc_o          <= 32'd0;
            wb_data_o     <= 32'd0;
            operand_a_o   <= 32'd0;
            operand_b_o   <= 32'd0;
            operand_imm_o <= 32'd0;
            wb_addr_o     <= 5'd0;
        end else if (!hold_i) begin
            if (accept) begin
                wb_flag_o     <= wb_flag_next;
                store_flag_o  <= store_flag_i;
                load_flag_o   <= load_flag_i;
                LSU_signed_o  <= LSU_signed_i;
                LSU_type_o    <= LSU_type_i;
                pc_o          <= pc_i;
                wb_data_o     <= wb_data_next;
                operand_a_o   <= operand_a_i;
                operand_b_o   <= operand_b_i;
                operand_imm_o <= operand_imm_i;
                wb_addr_o     <= wb_addr_i;
            end else begin
                wb_flag_o    <= 1'b0;
                store_flag_o <= 1'b0;
                load_flag_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060072_ex_stage.sv
// Self-checking bench for ysyx_23060072_ex_stage: directed corner cases plus
// random instructions compared against a behavioural model of the stage.
// Multiplier tests are included when YSYX_23060072_MUL_EN is defined.
module tb_ysyx_23060072_ex_stage;
    import ysyx_23060072_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, use_imm_i, branch_i, jal_i, jalr_i, mul_flag_i;
    logic [3:0]  alu_op_i;
    logic [2:0]  branch_type_i;
    logic [1:0]  mul_op_i, LSU_type_i;
    logic        wb_flag_i, store_flag_i, load_flag_i, LSU_signed_i, hold_i;
    logic [31:0] pc_i, operand_a_i, operand_b_i, operand_imm_i;
    logic [4:0]  wb_addr_i;
    logic        jump_flag_o, ex_hold_flag_o, wb_flag_o, store_flag_o, load_flag_o, LSU_signed_o;
    logic [31:0] jump_addr_o, pc_o, wb_data_o, operand_a_o, operand_b_o, operand_imm_o;
    logic [1:0]  LSU_type_o;
    logic [4:0]  wb_addr_o;

    int checks = 0;
    int failures = 0;

    // Expected contents of the EX/LSU register
    logic        exp_wb_flag, exp_store_flag, exp_load_flag, exp_signed;
    logic [1:0]  exp_type;
    logic [31:0] exp_pc, exp_wb_data, exp_a, exp_b, exp_imm;
    logic [4:0]  exp_wb_addr;
    logic        data_known;

    br_type_e br_list [6] = '{BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU};

    always #5 clk = ~clk;

    ysyx_23060072_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .alu_op_i(alu_op_i),
        .use_imm_i(use_imm_i), .branch_i(branch_i), .jal_i(jal_i), .jalr_i(jalr_i),
        .branch_type_i(branch_type_i), .mul_flag_i(mul_flag_i), .mul_op_i(mul_op_i),
        .wb_flag_i(wb_flag_i), .store_flag_i(store_flag_i), .load_flag_i(load_flag_i),
        .LSU_signed_i(LSU_signed_i), .LSU_type_i(LSU_type_i), .pc_i(pc_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .operand_imm_i(operand_imm_i),
        .wb_addr_i(wb_addr_i), .hold_i(hold_i), .jump_flag_o(jump_flag_o),
        .jump_addr_o(jump_addr_o), .ex_hold_flag_o(ex_hold_flag_o), .wb_flag_o(wb_flag_o),
        .store_flag_o(store_flag_o), .load_flag_o(load_flag_o), .LSU_signed_o(LSU_signed_o),
        .LSU_type_o(LSU_type_o), .pc_o(pc_o), .wb_data_o(wb_data_o),
        .operand_a_o(operand_a_o), .operand_b_o(operand_b_o),
        .operand_imm_o(operand_imm_o), .wb_addr_o(wb_addr_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference ALU written from the instruction semantics
    function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] pc);
        int unsigned sh;
        longint sa, sb;
        sh = b % 32;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << sh;
            4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> sh;
            4'd7:  return (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            4'd11: return pc + b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic refTaken(input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (bt)
            BR_BEQ:  return a == b;
            BR_BNE:  return a != b;
            BR_BLT:  return sa < sb;
            BR_BGE:  return sa >= sb;
            BR_BLTU: return longint'(a) < longint'(b);
            BR_BGEU: return longint'(a) >= longint'(b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h7FFFFFFF;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic clearInputs();
        valid_i = 0; use_imm_i = 0; branch_i = 0; jal_i = 0; jalr_i = 0; mul_flag_i = 0;
        alu_op_i = 0; branch_type_i = 0; mul_op_i = 0; LSU_type_i = 0;
        wb_flag_i = 0; store_flag_i = 0; load_flag_i = 0; LSU_signed_i = 0; hold_i = 0;
        pc_i = 0; operand_a_i = 0; operand_b_i = 0; operand_imm_i = 0; wb_addr_i = 0;
    endtask

    task automatic setAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        clearInputs();
        valid_i = 1; wb_flag_i = 1; alu_op_i = op; operand_a_i = a; operand_b_i = b;
        wb_addr_i = 5'd5; pc_i = 32'h80000000;
    endtask

    // Check the combinational redirect, clock once, then check the register
    task automatic applyStimulus();
        logic accept, exp_jump;
        logic [31:0] bsrc, exp_jaddr;
        #1;
        accept    = rst_n && valid_i && !hold_i;
        bsrc      = use_imm_i ? operand_imm_i : operand_b_i;
        exp_jump  = accept && (jal_i || jalr_i || (branch_i && refTaken(branch_type_i, operand_a_i, operand_b_i)));
        exp_jaddr = jalr_i ? ((operand_a_i + operand_imm_i) / 2) * 2 : pc_i + operand_imm_i;
        checkOutput("jump_flag", 32'(jump_flag_o), 32'(exp_jump));
        if (exp_jump) checkOutput("jump_addr", jump_addr_o, exp_jaddr);
        checkOutput("ex_hold", 32'(ex_hold_flag_o), 32'd0);
        if (!rst_n) begin
            exp_wb_flag = 0; exp_store_flag = 0; exp_load_flag = 0; exp_signed = 0; exp_type = 0;
            exp_pc = 0; exp_wb_data = 0; exp_a = 0; exp_b = 0; exp_imm = 0; exp_wb_addr = 0;
            data_known = 1;
        end else if (!hold_i) begin
            if (accept) begin
                exp_wb_data    = (jal_i || jalr_i) ? pc_i + 32'd4 : refAlu(alu_op_i, operand_a_i, bsrc, pc_i);
                exp_wb_flag    = wb_flag_i && !mul_flag_i;
                exp_store_flag = store_flag_i;
                exp_load_flag  = load_flag_i;
                exp_signed     = LSU_signed_i;
                exp_type       = LSU_type_i;
                exp_pc         = pc_i;
                exp_a          = operand_a_i;
                exp_b          = operand_b_i;
                exp_imm        = operand_imm_i;
                exp_wb_addr    = wb_addr_i;
                data_known     = !mul_flag_i;
            end else begin
                exp_wb_flag = 0; exp_store_flag = 0; exp_load_flag = 0;
                data_known = 0;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("wb_flag", 32'(wb_flag_o), 32'(exp_wb_flag));
        checkOutput("store_flag", 32'(store_flag_o), 32'(exp_store_flag));
        checkOutput("load_flag", 32'(load_flag_o), 32'(exp_load_flag));
        if (data_known) begin
            checkOutput("wb_data", wb_data_o, exp_wb_data);
            checkOutput("pc", pc_o, exp_pc);
            checkOutput("operand_a", operand_a_o, exp_a);
            checkOutput("operand_b", operand_b_o, exp_b);
            checkOutput("operand_imm", operand_imm_o, exp_imm);
            checkOutput("wb_addr", 32'(wb_addr_o), 32'(exp_wb_addr));
            checkOutput("lsu_signed", 32'(LSU_signed_o), 32'(exp_signed));
            checkOutput("lsu_type", 32'(LSU_type_o), 32'(exp_type));
        end
    endtask

`ifdef YSYX_23060072_MUL_EN
    task automatic runMul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv);
        int cnt;
        clearInputs();
        valid_i = 1; mul_flag_i = 1; mul_op_i = op; wb_flag_i = 1;
        operand_a_i = a; operand_b_i = b; wb_addr_i = 5'd7; pc_i = 32'h200;
        #1;
        cnt = 0;
        while (ex_hold_flag_o && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
            if (ex_hold_flag_o) checkOutput("mul_bubble", 32'(wb_flag_o), 32'd0);
        end
        checkOutput("mul_hold_cycles", 32'(cnt), 32'd33);
        @(posedge clk);
        #1;
        checkOutput("mul_wb_flag", 32'(wb_flag_o), 32'd1);
        checkOutput("mul_result", wb_data_o, expv);
        exp_wb_flag = 1; exp_store_flag = 0; exp_load_flag = 0; exp_signed = 0; exp_type = 0;
        exp_pc = 32'h200; exp_wb_data = expv; exp_a = a; exp_b = b; exp_imm = 0;
        exp_wb_addr = 5'd7; data_known = 1;
        clearInputs();
    endtask
`endif

    initial begin
        $display("[TB] start");
        clearInputs();
        rst_n = 0;
        applyStimulus();
        applyStimulus();
        rst_n = 1;

        // Arithmetic corner cases with explicit expected values
        setAlu(ALU_ADD, 32'h7FFFFFFF, 32'd1);
        applyStimulus();
        checkOutput("add_overflow", wb_data_o, 32'h80000000);
        setAlu(ALU_SRA, 32'h80000000, 32'd4);
        applyStimulus();
        checkOutput("sra_sign", wb_data_o, 32'hF8000000);
        setAlu(ALU_SLTU, 32'd1, 32'hFFFFFFFF);
        applyStimulus();
        checkOutput("sltu", wb_data_o, 32'd1);

        // Signed vs unsigned branch on the same operand pair
        clearInputs();
        valid_i = 1; branch_i = 1; branch_type_i = BR_BLT;
        operand_a_i = 32'hFFFFFFFF; operand_b_i = 32'd1; pc_i = 32'h80000010; operand_imm_i = 32'hFFFFFFF0;
        #1;
        checkOutput("blt_taken", 32'(jump_flag_o), 32'd1);
        checkOutput("blt_addr", jump_addr_o, 32'h80000000);
        applyStimulus();
        valid_i = 0;
        applyStimulus();
        valid_i = 1; branch_type_i = BR_BLTU;
        applyStimulus();

        // JALR held for three cycles, then released
        clearInputs();
        valid_i = 1; jalr_i = 1; wb_flag_i = 1; pc_i = 32'h100; operand_a_i = 32'h2003;
        wb_addr_i = 5'd1; hold_i = 1;
        for (int i = 0; i < 3; i++) applyStimulus();
        hold_i = 0;
        #1;
        checkOutput("jalr_addr", jump_addr_o, 32'h2002);
        applyStimulus();
        checkOutput("jalr_link", wb_data_o, 32'h104);
        valid_i = 0;
        applyStimulus();

        // Load held, then released
        clearInputs();
        valid_i = 1; load_flag_i = 1; wb_flag_i = 1; use_imm_i = 1; LSU_type_i = LSU_WORD;
        operand_a_i = 32'h1000; operand_imm_i = 32'h24; wb_addr_i = 5'd9; hold_i = 1;
        applyStimulus();
        applyStimulus();
        hold_i = 0;
        applyStimulus();
        checkOutput("load_flag_rel", 32'(load_flag_o), 32'd1);
        checkOutput("load_a", operand_a_o, 32'h1000);
        checkOutput("load_imm", operand_imm_o, 32'h24);

        // Reset mid-stream with a jump presented
        clearInputs();
        valid_i = 1; jal_i = 1; wb_flag_i = 1; pc_i = 32'h40; operand_imm_i = 32'h10;
        rst_n = 0;
        applyStimulus();
        applyStimulus();
        rst_n = 1;

`ifdef YSYX_23060072_MUL_EN
        runMul(MUL_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        runMul(MUL_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        runMul(MUL_MUL, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB);
        runMul(MUL_MULHSU, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF);
        // Reset while busy returns the multiplier to idle
        clearInputs();
        valid_i = 1; mul_flag_i = 1; wb_flag_i = 1; operand_a_i = 32'd3; operand_b_i = 32'd5;
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        valid_i = 0; mul_flag_i = 0; rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        checkOutput("mul_reset_idle", 32'(ex_hold_flag_o), 32'd0);
        checkOutput("mul_reset_wb", 32'(wb_flag_o), 32'd0);
        exp_wb_flag = 0; exp_store_flag = 0; exp_load_flag = 0; exp_signed = 0; exp_type = 0;
        exp_pc = 0; exp_wb_data = 0; exp_a = 0; exp_b = 0; exp_imm = 0; exp_wb_addr = 0;
        data_known = 1;
`endif

        // Random instruction stream against the model
        for (int i = 0; i < 300; i++) begin
            int cls;
            clearInputs();
            cls           = int'($urandom_range(0, 5));
            valid_i       = ($urandom_range(0, 9) != 0);
            hold_i        = ($urandom_range(0, 4) == 0);
            alu_op_i      = 4'($urandom_range(0, 11));
            use_imm_i     = 1'($urandom);
            operand_a_i   = pickVal();
            operand_b_i   = pickVal();
            operand_imm_i = pickVal();
            pc_i          = $urandom & 32'hFFFFFFFC;
            wb_addr_i     = 5'($urandom);
            LSU_type_i    = 2'($urandom_range(0, 2));
            LSU_signed_i  = 1'($urandom);
            case (cls)
                0: wb_flag_i = 1;
                1: begin branch_i = 1; branch_type_i = br_list[$urandom_range(0, 5)]; end
                2: begin jal_i = 1; wb_flag_i = 1; end
                3: begin jalr_i = 1; wb_flag_i = 1; end
                4: begin load_flag_i = 1; wb_flag_i = 1; end
                default: store_flag_i = 1;
            endcase
`ifndef YSYX_23060072_MUL_EN
            if (cls == 0 && $urandom_range(0, 7) == 0) mul_flag_i = 1;
`endif
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
